// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch stage.
//   - XLEN             : datapath / address width
//   - RESET_PC_DEFAULT : default first PC fetched after reset
//   - PC_STEP_DEFAULT  : default sequential PC increment in bytes
//   - state_e          : fetch-stage control state (BOOT / RUN / FAULT)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int              PC_STEP_DEFAULT  = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,   // one idle cycle after reset release
        RUN   = 2'd1,   // normal fetching
        FAULT = 2'd2    // misaligned redirect seen; absorbing until reset
    } state_e;

endpackage : fetch_pkg

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   PC-generation and fetch stage sitting directly in front of a
//   synchronous-read instruction memory. Issues one read per cycle, tracks the
//   one-cycle read latency and presents {pc, instr} to the decoder with a
//   valid/ready handshake. Supports back-pressure, redirects that squash the
//   wrong-path response, a sticky misaligned-redirect fault and a counter of
//   accepted instructions.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_addr      out  byte address to instruction memory
//   imem_en        out  memory chip select; a read is issued at the edge
//   imem_instr     in   memory read data (valid the cycle after the issue)
//   redirect_valid in   single-cycle redirect request
//   redirect_pc    in   redirect target
//   out_valid      out  out_instr/out_pc valid to the decoder
//   out_ready      in   decoder accepts this cycle
//   out_instr      out  fetched instruction
//   out_pc         out  PC of out_instr
//   fault          out  sticky misaligned-redirect fault
//   instr_count    out  number of instructions accepted by the decoder
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_en,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fault,
    output logic [XLEN-1:0] instr_count
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_pc_q;
    logic            fault_q;
    logic [XLEN-1:0] instr_count_q;

    logic run;
    logic mis;
    logic fire;

    // Redirect target whose low bits are not word aligned.
    assign mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign run  = (state_q == RUN);
    assign fire = out_valid && out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;                  // redirects ignored here
            RUN:     if (mis) state_d = FAULT;
            FAULT:   state_d = FAULT;                // only rst_n leaves
            default: state_d = BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_addr = redirect_valid ? redirect_pc : fetch_pc_q;
        imem_en   = 1'b0;
        out_valid = 1'b0;
        if (run) begin
            // Issue whenever the response slot is free or will be freed this
            // cycle (accepted, or squashed by a redirect). A misaligned target
            // is never sent to memory.
            imem_en   = !mis && (redirect_valid || !resp_valid_q || out_ready);
            // A redirect squashes the response currently on display.
            out_valid = resp_valid_q && !redirect_valid;
        end
    end

    assign out_instr   = imem_instr;   // memory holds its output while not enabled
    assign out_pc      = resp_pc_q;
    assign fault       = fault_q;
    assign instr_count = instr_count_q;

    // ------------------------------------------------------------------
    // Fetch datapath: PC, in-flight response tracking, fault, counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_valid_q  <= 1'b0;
            resp_pc_q     <= '0;
            fault_q       <= 1'b0;
            instr_count_q <= '0;
        end else begin
            if (imem_en) begin
                // Next-cycle memory output belongs to imem_addr; the PC adder
                // wraps naturally at 2^XLEN.
                resp_valid_q <= 1'b1;
                resp_pc_q    <= imem_addr;
                fetch_pc_q   <= imem_addr + XLEN'(PC_STEP);
            end else if (fire) begin
                resp_valid_q <= 1'b0;
            end

            // imem_en is low whenever mis is high, so this never collides
            // with the issue branch above.
            if (run && mis) begin
                resp_valid_q <= 1'b0;
                fault_q      <= 1'b1;
            end

            if (fire) begin
                instr_count_q <= instr_count_q + 32'd1;
            end
        end
    end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. A behavioural synchronous-read memory
//   returns 32'hA000_0000 + word_index. Expected accepted {pc, instr} pairs are
//   queued by each scenario as it drives stimulus and popped whenever the
//   decoder handshake fires; instr_count is compared with the bench's own
//   count of accepted instructions every cycle.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] instr_count;

    int          passed;
    int          total;
    logic [31:0] exp_q[$];
    logic [31:0] exp_count;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .instr_count    (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return 32'hA000_0000 + {2'b00, addr[31:2]};
    endfunction

    // Synchronous-read memory: output updates only on an enabled edge.
    always @(posedge clk) begin
        if (imem_en === 1'b1) imem_instr <= word_of(imem_addr);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance to the middle of the next cycle; caller then drives inputs.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Let inputs settle, then check the counter and pop on a handshake.
    task automatic sb_check(input string tag);
        logic [31:0] e;
        #1;
        total++;
        if (instr_count !== exp_count)
            $display("FAIL %s instr_count: got %h expected %h", tag, instr_count, exp_count);
        else
            passed++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s unexpected accept: got pc %h instr %h expected none", tag, out_pc, out_instr);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e || out_instr !== word_of(e))
                    $display("FAIL %s accept: got pc %h instr %h expected pc %h instr %h",
                             tag, out_pc, out_instr, e, word_of(e));
                else
                    passed++;
            end
            exp_count++;
        end
    endtask

    task automatic drain_check(input string tag);
        total++;
        if (exp_q.size() != 0)
            $display("FAIL %s drain: got %0d pending expected 0 (next pc %h)", tag, exp_q.size(), exp_q[0]);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_count      = 32'h0;
        #3;
        total++;
        if (out_valid !== 1'b0 || imem_en !== 1'b0 || fault !== 1'b0 ||
            instr_count !== 32'h0 || imem_addr !== 32'h0)
            $display("FAIL reset_values: got v=%b en=%b f=%b cnt=%h addr=%h expected 0 0 0 0 0",
                     out_valid, imem_en, fault, instr_count, imem_addr);
        else
            passed++;
    endtask

    task automatic test_stream();
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++;
        if (imem_en !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL boot_idle: got en=%b v=%b expected 0 0", imem_en, out_valid);
        else
            passed++;
        next_cycle();
        sb_check("stream_first_issue");
        total++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0)
            $display("FAIL first_issue: got en=%b addr=%h v=%b expected 1 0 0", imem_en, imem_addr, out_valid);
        else
            passed++;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        next_cycle();
        sb_check("stream_pc0");
        total++;
        if (imem_addr !== 32'h4 || imem_en !== 1'b1)
            $display("FAIL stream_addr: got addr=%h en=%b expected 4 1", imem_addr, imem_en);
        else
            passed++;
        next_cycle();
        sb_check("stream_pc4");
        drain_check("stream");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            out_ready = 1'b0;
            sb_check("stall");
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'hA000_0002 || imem_en !== 1'b0)
                $display("FAIL stall_hold: got v=%b pc=%h instr=%h en=%b expected 1 8 a0000002 0",
                         out_valid, out_pc, out_instr, imem_en);
            else
                passed++;
        end
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        next_cycle();
        out_ready = 1'b1;
        sb_check("stall_release_pc8");
        next_cycle();
        sb_check("stall_release_pc12");
        drain_check("stall");
    endtask

    task automatic test_redirect();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sb_check("redirect_squash");
        total++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h100 || imem_en !== 1'b1)
            $display("FAIL redirect_issue: got v=%b addr=%h en=%b expected 0 100 1", out_valid, imem_addr, imem_en);
        else
            passed++;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            redirect_valid = 1'b0;
            sb_check("redirect_target");
        end
        drain_check("redirect");
    endtask

    task automatic test_wrap();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        sb_check("wrap_redirect");
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            redirect_valid = 1'b0;
            sb_check("wrap_stream");
        end
        drain_check("wrap");
    endtask

    task automatic test_fault();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        sb_check("fault_trigger");
        total++;
        if (imem_en !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL fault_no_issue: got en=%b v=%b expected 0 0", imem_en, out_valid);
        else
            passed++;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            redirect_valid = (i % 2 == 0);
            redirect_pc    = (i % 3 == 0) ? 32'h200 : 32'h2;
            sb_check("fault_absorb");
            total++;
            if (fault !== 1'b1 || imem_en !== 1'b0 || out_valid !== 1'b0)
                $display("FAIL fault_hold: got f=%b en=%b v=%b expected 1 0 0", fault, imem_en, out_valid);
            else
                passed++;
        end
        next_cycle();
        redirect_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (fault !== 1'b0 || imem_en !== 1'b0 || out_valid !== 1'b0 || instr_count !== 32'h0)
            $display("FAIL fault_reset: got f=%b en=%b v=%b cnt=%h expected 0 0 0 0",
                     fault, imem_en, out_valid, instr_count);
        else
            passed++;
        exp_q.delete();
        exp_count = 32'h0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++;
        if (imem_en !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL fault_reboot_idle: got en=%b v=%b expected 0 0", imem_en, out_valid);
        else
            passed++;
        next_cycle();
        sb_check("fault_reboot");
        total++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL fault_reboot_issue: got en=%b addr=%h expected 1 0", imem_en, imem_addr);
        else
            passed++;
    endtask

    task automatic test_async_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        next_cycle();
        sb_check("areset_pc0");
        next_cycle();
        sb_check("areset_pc4");
        // Midway between edges: outputs must clear without a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || imem_en !== 1'b0 || fault !== 1'b0 || instr_count !== 32'h0)
            $display("FAIL async_reset: got v=%b en=%b f=%b cnt=%h expected 0 0 0 0",
                     out_valid, imem_en, fault, instr_count);
        else
            passed++;
        exp_q.delete();
        exp_count = 32'h0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++;
        if (imem_en !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL areset_boot_idle: got en=%b v=%b expected 0 0", imem_en, out_valid);
        else
            passed++;
        next_cycle();
        sb_check("areset_restart");
        total++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL areset_restart_issue: got en=%b addr=%h expected 1 0", imem_en, imem_addr);
        else
            passed++;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sb_check("areset_stream");
        end
        drain_check("async_reset");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_fault();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_instr_fetch
